uart_tx_fifo: RTL and testbench
===============================

Name: uart_tx_fifo

Overview:
UART serial transmitter with a small input FIFO: 8N1 framing, LSB first, 115200 baud at 100 MHz by default. Mirror of the receive path. Accepts bytes from the command/result logic over a valid/ready handshake, buffers them, and serialises them back-to-back on the uart_tx pin. Sits between the matrix-calc result formatter and the board TX pin.

Parameters:
CLK_DIV, 868, clock cycles per bit (100 MHz / 115200); legal range 4..1023
FIFO_DEPTH, 4, byte FIFO entries; power of two, 2..16
FIFO_AW, 2, log2(FIFO_DEPTH)

Ports:
clk  input  1  system clock, 100 MHz
rst  input  1  synchronous, active-high reset
tx_data  input  8  byte to send
tx_valid  input  1  tx_data is valid this cycle
tx_ready  output  1  FIFO can accept; tx_ready = (fifo_count < FIFO_DEPTH)
uart_tx  output  1  serial line, registered, idle high
tx_busy  output  1  high when a frame is in progress or FIFO is non-empty
fifo_count  output  FIFO_AW+1  bytes currently buffered, excluding the byte being shifted

Behaviour:
- One clock; reset is synchronous and active-high. While rst=1 at a clk edge: state<=IDLE, uart_tx<=1, FIFO pointers and count<=0, bit counter and baud counter<=0. Consequences: tx_ready=1, tx_busy=0, fifo_count=0.
- Reset mid-frame aborts the frame. uart_tx is high from the edge where rst is sampled. Buffered bytes are discarded.
- Push: at an edge with tx_valid && tx_ready, tx_data is written and fifo_count increments. tx_valid while tx_ready=0 is ignored: no write, no error. tx_data is not required stable beyond the accepting edge.
- Pop: happens only in the FSM at the frame-load edge. A pop and a push on the same edge leave fifo_count unchanged. Pop never occurs when the FIFO is empty. Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, START, DATA, STOP (plus PARITY, see below).
- IDLE: uart_tx=1. If fifo_count!=0: pop the head into the shift register, uart_tx<=0, baud counter<=0, go to START.
- START: holds uart_tx=0 for exactly CLK_DIV cycles. On the last cycle: uart_tx<=shift[0], bit index<=0, go to DATA.
- DATA: each bit is held exactly CLK_DIV cycles, LSB first. After bit 7 completes: uart_tx<=1, go to STOP.
- STOP: uart_tx=1 for exactly CLK_DIV cycles. On the last cycle:
  - if fifo_count!=0: pop, uart_tx<=0, go to START (no idle gap between frames);
  - else go to IDLE.
- Timing: uart_tx falls on the edge after the accepting edge when the FSM is IDLE. Each frame is exactly 10*CLK_DIV cycles. Back-to-back frames are contiguous.
- tx_busy = (state!=IDLE) || (fifo_count!=0), registered-equivalent. It falls on the edge the FSM returns to IDLE with an empty FIFO.
- Baud counter is CLK_DIV-wide ($clog2(CLK_DIV)); it counts 0..CLK_DIV-1 and wraps to 0 at each bit boundary.

Optional Feature:
UART_TX_PARITY_EN
- Defined: a PARITY state follows DATA. uart_tx carries the even parity bit (XOR of the 8 data bits) for CLK_DIV cycles, then goes to STOP. Frame = 11*CLK_DIV cycles.
- Undefined: no PARITY state and no parity logic; 8N1 framing, 10*CLK_DIV cycles.

Test Plan:
- Reset, then idle 100 cycles -> uart_tx=1, tx_ready=1, tx_busy=0, fifo_count=0.
- CLK_DIV=16, push 0xA5 once -> uart_tx low 1 cycle after accept. Line sequence: 0,1,0,1,0,0,1,0,1,1, each level 16 cycles. tx_busy drops 160 cycles after the start edge.
- CLK_DIV=16, FIFO_DEPTH=4, tx_valid held high with 0x01..0x06 -> the first byte loads immediately and 4 more fill the FIFO, so tx_ready=0 after 5 accepts. 0x06 is accepted when the first frame ends. All six frames are contiguous with no idle gap; the loopback receiver decodes 0x01..0x06 in order.
- Push while full (tx_ready=0) with 0xFF -> byte not stored, fifo_count unchanged, 0xFF never appears on the line.
- Assert rst mid-DATA of 0x3C with 2 bytes queued -> uart_tx=1 on the next edge, fifo_count=0, tx_busy=0; no further frames start.
- With UART_TX_PARITY_EN, push 0x07 -> parity bit = 1, frame 11*CLK_DIV cycles; push 0x03 -> parity bit = 0.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter fed by a small byte FIFO, frames sent back-to-back.
// Define UART_TX_PARITY_EN to insert an even-parity bit after the data bits.
module uart_tx_fifo #(
  parameter int CLK_DIV    = 868,
  parameter int FIFO_DEPTH = 4,
  parameter int FIFO_AW    = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic             uart_tx,
  output logic             tx_busy,
  output logic [FIFO_AW:0] fifo_count
);

  localparam int BW = $clog2(CLK_DIV);
  localparam logic [BW-1:0] BAUD_MAX = BW'(CLK_DIV - 1);
  localparam logic [FIFO_AW:0] CNT_FULL = (FIFO_AW + 1)'(FIFO_DEPTH);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t state;
  state_t state_nxt;

  logic [7:0]         mem [FIFO_DEPTH];
  logic [FIFO_AW-1:0] wptr;
  logic [FIFO_AW-1:0] rptr;
  logic [7:0]         head;
  logic               push;
  logic               pop;
  logic               cnt_nz;

  logic [BW-1:0] baud;
  logic          tick;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic          tx_nxt;

`ifdef UART_TX_PARITY_EN
  logic          par;
`endif

  assign cnt_nz   = (fifo_count != '0);
  assign tx_ready = (fifo_count < CNT_FULL);
  assign push     = tx_valid && tx_ready;
  assign head     = mem[rptr];
  assign tick     = (baud == BAUD_MAX);

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= tx_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr       <= '0;
      rptr       <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wptr <= wptr + FIFO_AW'(1);
      if (pop)  rptr <= rptr + FIFO_AW'(1);
      unique case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      uart_tx <= 1'b1;
      baud    <= '0;
      bit_idx <= '0;
      shift   <= '0;
    end else begin
      state   <= state_nxt;
      uart_tx <= tx_nxt;
      baud    <= (state == IDLE || tick) ? '0 : baud + 1'b1;
      if (pop)
        shift <= head;
      else if (state == DATA && tick)
        shift <= {1'b0, shift[7:1]};
      if (state == START)
        bit_idx <= '0;
      else if (state == DATA && tick)
        bit_idx <= bit_idx + 3'd1;
    end
  end

`ifdef UART_TX_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst)      par <= 1'b0;
    else if (pop) par <= ^head;
  end
`endif

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (cnt_nz) state_nxt = START;
      START: if (tick) state_nxt = DATA;
`ifdef UART_TX_PARITY_EN
      DATA:   if (tick && bit_idx == 3'd7) state_nxt = PARITY;
      PARITY: if (tick) state_nxt = STOP;
`else
      DATA:  if (tick && bit_idx == 3'd7) state_nxt = STOP;
`endif
      STOP:  if (tick) state_nxt = cnt_nz ? START : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Line level is computed one cycle ahead so uart_tx comes straight from a flop
  always_comb begin
    pop    = 1'b0;
    tx_nxt = uart_tx;
    unique case (state)
      IDLE: begin
        tx_nxt = 1'b1;
        if (cnt_nz) begin
          pop    = 1'b1;
          tx_nxt = 1'b0;
        end
      end
      START: if (tick) tx_nxt = shift[0];
      DATA: begin
        if (tick) begin
          if (bit_idx == 3'd7)
`ifdef UART_TX_PARITY_EN
            tx_nxt = par;
`else
            tx_nxt = 1'b1;
`endif
          else
            tx_nxt = shift[1];
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: if (tick) tx_nxt = 1'b1;
`endif
      STOP: begin
        if (tick) begin
          if (cnt_nz) begin
            pop    = 1'b1;
            tx_nxt = 1'b0;
          end else begin
            tx_nxt = 1'b1;
          end
        end
      end
      default: tx_nxt = 1'b1;
    endcase
  end

  assign tx_busy = (state != IDLE) || cnt_nz;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with CLK_DIV=16, FIFO_DEPTH=4.
// Line levels are checked at the first and last cycle of every bit.
module tb_uart_tx_fifo;

  localparam int DIV   = 16;
  localparam int DEPTH = 4;
  localparam int AW    = 2;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          tx_ready;
  logic          uart_tx;
  logic          tx_busy;
  logic [AW:0]   fifo_count;

  int tests = 0;
  int fails = 0;

  uart_tx_fifo #(
    .CLK_DIV(DIV),
    .FIFO_DEPTH(DEPTH),
    .FIFO_AW(AW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .tx_data(tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .uart_tx(uart_tx),
    .tx_busy(tx_busy),
    .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_bit(input logic [7:0] d, input int b);
    if (b == 0) return 1'b0;
    if (b <= 8) return d[b-1];
    if (NB == 11 && b == 9) return ^d;
    return 1'b1;
  endfunction

  // Call at the negedge right after the start-bit edge.
  task automatic chk_frame(input string tag, input logic [7:0] d);
    for (int b = 0; b < NB; b++) begin
      chk($sformatf("%s bit%0d first", tag, b), 32'(uart_tx), 32'(exp_bit(d, b)));
      repeat (DIV - 1) @(negedge clk);
      chk($sformatf("%s bit%0d last", tag, b), 32'(uart_tx), 32'(exp_bit(d, b)));
      chk($sformatf("%s bit%0d busy", tag, b), 32'(tx_busy), 1);
      @(negedge clk);
    end
  endtask

  initial begin
    int lows;
    rst      = 1'b1;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (100) @(negedge clk);
    chk("idle uart_tx", 32'(uart_tx), 1);
    chk("idle tx_ready", 32'(tx_ready), 1);
    chk("idle tx_busy", 32'(tx_busy), 0);
    chk("idle fifo_count", 32'(fifo_count), 0);

    // single byte 0xA5
    tx_data  = 8'hA5;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    chk("a5 count after accept", 32'(fifo_count), 1);
    chk("a5 line still idle", 32'(uart_tx), 1);
    @(negedge clk);
    chk("a5 start fall", 32'(uart_tx), 0);
    chk("a5 count after load", 32'(fifo_count), 0);
    chk("a5 busy", 32'(tx_busy), 1);
    chk_frame("a5", 8'hA5);
    chk("a5 busy drop", 32'(tx_busy), 0);
    chk("a5 line idle", 32'(uart_tx), 1);
    repeat (5) @(negedge clk);

    // back-to-back 0x01..0x06 with a blocked 0xFF push while full
    fork
      begin
        int w;
        for (int i = 1; i <= 6; i++) begin
          tx_data  = 8'(i);
          tx_valid = 1'b1;
          w = 0;
          while (!tx_ready && w < 1000) begin
            @(negedge clk);
            w++;
          end
          chk($sformatf("feed%0d wait", i), 32'(w < 1000), 1);
          @(negedge clk);
          if (i == 5) begin
            chk("full tx_ready", 32'(tx_ready), 0);
            chk("full count", 32'(fifo_count), 4);
            tx_data = 8'hFF;
            repeat (3) @(negedge clk);
            chk("ff ignored count", 32'(fifo_count), 4);
            chk("ff ignored ready", 32'(tx_ready), 0);
          end
        end
        tx_valid = 1'b0;
      end
      begin
        int w;
        w = 0;
        while (uart_tx !== 1'b0 && w < 100) begin
          @(negedge clk);
          w++;
        end
        chk("b2b start seen", 32'(w < 100), 1);
        for (int f = 1; f <= 6; f++)
          chk_frame($sformatf("b2b%0d", f), 8'(f));
      end
    join
    chk("b2b end busy", 32'(tx_busy), 0);
    chk("b2b end count", 32'(fifo_count), 0);
    chk("b2b end line", 32'(uart_tx), 1);
    repeat (5) @(negedge clk);

`ifdef UART_TX_PARITY_EN
    tx_data  = 8'h07;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    @(negedge clk);
    chk_frame("par07", 8'h07);
    chk("par07 busy drop", 32'(tx_busy), 0);
    tx_data  = 8'h03;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    @(negedge clk);
    chk_frame("par03", 8'h03);
    chk("par03 busy drop", 32'(tx_busy), 0);
    repeat (5) @(negedge clk);
`endif

    // reset during data bit 0 of 0x3C with two bytes queued
    tx_valid = 1'b1;
    tx_data  = 8'h3C;
    @(negedge clk);
    tx_data = 8'h11;
    @(negedge clk);
    tx_data = 8'h22;
    @(negedge clk);
    tx_valid = 1'b0;
    repeat (22) @(negedge clk);
    chk("pre-rst line low", 32'(uart_tx), 0);
    chk("pre-rst count", 32'(fifo_count), 2);
    rst = 1'b1;
    @(negedge clk);
    chk("rst line high", 32'(uart_tx), 1);
    chk("rst count", 32'(fifo_count), 0);
    chk("rst busy", 32'(tx_busy), 0);
    chk("rst ready", 32'(tx_ready), 1);
    rst  = 1'b0;
    lows = 0;
    repeat (400) begin
      @(negedge clk);
      if (uart_tx !== 1'b1) lows++;
    end
    chk("post-rst no frames", 32'(lows), 0);
    chk("post-rst busy", 32'(tx_busy), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
